// File: rtl/pacman_steering.sv
`default_nettype none
// ============================================================================
// Module      : pacman_steering
// Description : Buffers the latest direction button as a pending turn, probes
//               the maze map on each move tick and drives heading/blocked.
// Revision    : 1.0 - initial release
// ============================================================================
module pacman_steering #(
    parameter int RESET_DIR  = 3,
    parameter int HOLD_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       btn_up,
    input  logic       btn_left,
    input  logic       btn_down,
    input  logic       btn_right,
    input  logic [4:0] tile_x,
    input  logic [4:0] tile_y,
    output logic [4:0] probe_x,
    output logic [4:0] probe_y,
    input  logic       probe_wall,
    output logic [1:0] direction,
    output logic       blocked,
    output logic       busy
);

    localparam int c_CNT_W = $clog2(HOLD_TICKS + 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_P_PEND = 3'd1;
    localparam logic [2:0] c_ST_W_PEND = 3'd2;
    localparam logic [2:0] c_ST_D_PEND = 3'd3;
    localparam logic [2:0] c_ST_P_CUR  = 3'd4;
    localparam logic [2:0] c_ST_W_CUR  = 3'd5;
    localparam logic [2:0] c_ST_D_CUR  = 3'd6;

    logic [3:0]         w_btn;
    logic [3:0]         r_sync1;
    logic [3:0]         r_sync2;
    logic               w_any;
    logic [1:0]         w_enc;
    logic               r_pend_valid;
    logic [1:0]         r_pend_dir;
    logic [c_CNT_W-1:0] r_hold_cnt;
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               w_turn_ok;
    logic [9:0]         w_cand_pend;
    logic [9:0]         w_cand_cur;
    logic [4:0]         r_probe_x;
    logic [4:0]         r_probe_y;
    logic [1:0]         r_direction;
    logic               r_blocked;

    // Neighbour tile {x, y} in the given heading, wrapping modulo 32.
    function automatic logic [9:0] f_cand(input logic [1:0] dir,
                                          input logic [4:0] x,
                                          input logic [4:0] y);
        logic [4:0] nx;
        logic [4:0] ny;
        nx = x;
        ny = y;
        case (dir)
            2'd0:    ny = y - 5'd1;
            2'd1:    nx = x - 5'd1;
            2'd2:    ny = y + 5'd1;
            default: nx = x + 5'd1;
        endcase
        return {nx, ny};
    endfunction

    assign w_btn = {btn_right, btn_down, btn_left, btn_up};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 4'd0;
            r_sync2 <= 4'd0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_any = |r_sync2;
        w_enc = 2'd3;
        if (r_sync2[0])      w_enc = 2'd0;
        else if (r_sync2[1]) w_enc = 2'd1;
        else if (r_sync2[2]) w_enc = 2'd2;
    end

    assign w_turn_ok = (r_state == c_ST_D_PEND) && !probe_wall;

    // A fresh press always overrides both hold expiry and a completed turn.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_dir   <= 2'd0;
            r_hold_cnt   <= '0;
        end else if (w_any) begin
            r_pend_valid <= 1'b1;
            r_pend_dir   <= w_enc;
            r_hold_cnt   <= c_CNT_W'(HOLD_TICKS);
        end else begin
            if (ce && r_pend_valid) begin
                r_hold_cnt <= r_hold_cnt - c_CNT_W'(1);
                if (r_hold_cnt == c_CNT_W'(1)) begin
                    r_pend_valid <= 1'b0;
                end
            end
            if (w_turn_ok) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (ce) w_state_nxt = r_pend_valid ? c_ST_P_PEND : c_ST_P_CUR;
            c_ST_P_PEND: w_state_nxt = c_ST_W_PEND;
            c_ST_W_PEND: w_state_nxt = c_ST_D_PEND;
            c_ST_D_PEND: w_state_nxt = probe_wall ? c_ST_P_CUR : c_ST_IDLE;
            c_ST_P_CUR:  w_state_nxt = c_ST_W_CUR;
            c_ST_W_CUR:  w_state_nxt = c_ST_D_CUR;
            c_ST_D_CUR:  w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign w_cand_pend = f_cand(r_pend_dir, tile_x, tile_y);
    assign w_cand_cur  = f_cand(r_direction, tile_x, tile_y);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_probe_x   <= 5'd0;
            r_probe_y   <= 5'd0;
            r_direction <= 2'(RESET_DIR);
            r_blocked   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_P_PEND: {r_probe_x, r_probe_y} <= w_cand_pend;
                c_ST_D_PEND: begin
                    if (!probe_wall) begin
                        r_direction <= r_pend_dir;
                        r_blocked   <= 1'b0;
                    end
                end
                c_ST_P_CUR:  {r_probe_x, r_probe_y} <= w_cand_cur;
                c_ST_D_CUR:  r_blocked <= probe_wall;
                default: ;
            endcase
        end
    end

    assign probe_x   = r_probe_x;
    assign probe_y   = r_probe_y;
    assign direction = r_direction;
    assign blocked   = r_blocked;
    assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pacman_steering.sv
`default_nettype none
// ============================================================================
// Module      : tb_pacman_steering
// Description : Directed bench for pacman_steering with an event-schedule model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pacman_steering;

    localparam int RESET_DIR  = 3;
    localparam int HOLD_TICKS = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_right = 1'b0;
    logic [4:0] tile_x = 5'd0;
    logic [4:0] tile_y = 5'd0;
    logic [4:0] probe_x;
    logic [4:0] probe_y;
    logic       probe_wall = 1'b0;
    logic [1:0] direction;
    logic       blocked;
    logic       busy;

    bit wall [32][32];   // indexed [y][x]
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pacman_steering #(
        .RESET_DIR (RESET_DIR),
        .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .btn_up    (btn_up),
        .btn_left  (btn_left),
        .btn_down  (btn_down),
        .btn_right (btn_right),
        .tile_x    (tile_x),
        .tile_y    (tile_y),
        .probe_x   (probe_x),
        .probe_y   (probe_y),
        .probe_wall(probe_wall),
        .direction (direction),
        .blocked   (blocked),
        .busy      (busy)
    );

    // Synchronous map ROM: one register stage behind the probe address.
    always @(posedge clk) probe_wall <= wall[probe_y][probe_x];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int step_x(input int d);
        return (d == 1) ? -1 : ((d == 3) ? 1 : 0);
    endfunction

    function automatic int step_y(input int d);
        return (d == 0) ? -1 : ((d == 2) ? 1 : 0);
    endfunction

    function automatic int wrap32(input int v);
        return (v + 32) % 32;
    endfunction

    // Model: an accepted tick schedules its future output updates by edge number.
    typedef struct {
        int t;
        int kind;   // 0 probe address, 1 turn taken, 2 blocked value
        int a;
        int b;
    } ev_t;

    ev_t m_q[$];
    int  m_edge = 0;
    int  m_until = 0;
    bit  m_busy = 0;
    bit  m_live = 0;
    int  m_dir, m_blk, m_px, m_py;
    bit  m_pvalid;
    int  m_pdir, m_hold;
    logic [3:0] m_s1, m_s2;

    always @(posedge clk) begin
        logic [3:0] raw;
        bit any;
        bit clr;
        int enc, px, py, cx, cy;
        raw = {btn_right, btn_down, btn_left, btn_up};
        if (reset) begin
            m_q.delete();
            m_until = 0;
            m_busy = 0;
            m_dir = RESET_DIR;
            m_blk = 0;
            m_px = 0;
            m_py = 0;
            m_pvalid = 0;
            m_pdir = 0;
            m_hold = 0;
            m_s1 = 4'd0;
            m_s2 = 4'd0;
            m_live = 1;
        end else begin
            any = (m_s2 != 4'd0);
            enc = 3;
            for (int i = 3; i >= 0; i--) if (m_s2[i]) enc = i;
            clr = 0;
            for (int i = m_q.size() - 1; i >= 0; i--) begin
                if (m_q[i].t == m_edge) begin
                    case (m_q[i].kind)
                        0: begin m_px = m_q[i].a; m_py = m_q[i].b; end
                        1: begin m_dir = m_q[i].a; m_blk = 0; clr = 1; end
                        default: m_blk = m_q[i].a;
                    endcase
                    m_q.delete(i);
                end
            end
            if (!m_busy && ce) begin
                cx = wrap32(int'(tile_x) + step_x(m_dir));
                cy = wrap32(int'(tile_y) + step_y(m_dir));
                if (m_pvalid) begin
                    px = wrap32(int'(tile_x) + step_x(m_pdir));
                    py = wrap32(int'(tile_y) + step_y(m_pdir));
                    m_q.push_back('{m_edge + 1, 0, px, py});
                    if (!wall[py][px]) begin
                        m_q.push_back('{m_edge + 3, 1, m_pdir, 0});
                        m_until = m_edge + 3;
                    end else begin
                        m_q.push_back('{m_edge + 4, 0, cx, cy});
                        m_q.push_back('{m_edge + 6, 2, int'(wall[cy][cx]), 0});
                        m_until = m_edge + 6;
                    end
                end else begin
                    m_q.push_back('{m_edge + 1, 0, cx, cy});
                    m_q.push_back('{m_edge + 3, 2, int'(wall[cy][cx]), 0});
                    m_until = m_edge + 3;
                end
            end
            if (any) begin
                m_pvalid = 1;
                m_pdir = enc;
                m_hold = HOLD_TICKS;
            end else begin
                if (ce && m_pvalid) begin
                    m_hold--;
                    if (m_hold == 0) m_pvalid = 0;
                end
                if (clr) m_pvalid = 0;
            end
            m_s2 = m_s1;
            m_s1 = raw;
            m_busy = (m_edge < m_until);
        end
        m_edge++;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_direction", direction, m_dir);
            chk("model_blocked", blocked, m_blk);
            chk("model_busy", busy, m_busy);
            chk("model_probe_x", probe_x, m_px);
            chk("model_probe_y", probe_y, m_py);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns one time unit after edge N, i.e. showing the "N+1" view.
    task automatic pulse_ce();
        ce = 1'b1;
        step(1);
        ce = 1'b0;
    endtask

    task automatic press(input bit u, input bit l, input bit d, input bit r);
        btn_up = u; btn_left = l; btn_down = d; btn_right = r;
        step(1);
        btn_up = 0; btn_left = 0; btn_down = 0; btn_right = 0;
        step(4);
    endtask

    task automatic clear_walls();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++)
                wall[y][x] = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        clear_walls();
        step(3);
        reset = 1'b0;
        step(1);
        chk("reset_direction", direction, 3);
        chk("reset_blocked", blocked, 0);
        chk("reset_busy", busy, 0);
        chk("reset_probe_x", probe_x, 0);
        chk("reset_probe_y", probe_y, 0);

        // Open turn up from (5,5)
        tile_x = 5'd5; tile_y = 5'd5;
        press(1, 0, 0, 0);
        pulse_ce();
        chk("open_busy_n1", busy, 1);
        step(1);
        chk("open_probe_x", probe_x, 5);
        chk("open_probe_y", probe_y, 4);
        step(2);
        chk("open_direction", direction, 0);
        chk("open_busy_n4", busy, 0);
        // Pending cleared: next tick takes the short current-heading path
        wall[4][5] = 1;
        pulse_ce();
        step(3);
        chk("cleared_busy", busy, 0);
        chk("cleared_blocked", blocked, 1);

        // Turn right, then a blocked left turn falling back to the right probe
        press(0, 0, 0, 1);
        pulse_ce();
        step(3);
        chk("right_direction", direction, 3);
        chk("right_blocked", blocked, 0);
        wall[5][4] = 1;
        wall[5][6] = 1;
        press(0, 1, 0, 0);
        pulse_ce();
        step(1);
        chk("fail_probe1_x", probe_x, 4);
        chk("fail_probe1_y", probe_y, 5);
        step(2);
        chk("fail_busy_n4", busy, 1);
        step(1);
        chk("fail_probe2_x", probe_x, 6);
        chk("fail_probe2_y", probe_y, 5);
        step(2);
        chk("fail_blocked_n7", blocked, 1);
        chk("fail_busy_n7", busy, 0);
        chk("fail_direction", direction, 3);
        pulse_ce();
        step(1);
        chk("retained_probe_x", probe_x, 4);
        step(6);

        // Hold expiry: down into a wall for 8 ticks, then only the heading is probed
        wall[6][5] = 1;
        press(0, 0, 1, 0);
        for (int i = 0; i < HOLD_TICKS; i++) begin
            pulse_ce();
            if (i == 0) begin
                step(1);
                chk("hold_probe_y", probe_y, 6);
                step(6);
            end else begin
                step(7);
            end
        end
        pulse_ce();
        step(1);
        chk("expired_probe_x", probe_x, 6);
        chk("expired_probe_y", probe_y, 5);
        step(2);
        chk("expired_busy", busy, 0);

        // Wrap-around and priority
        clear_walls();
        tile_x = 5'd0; tile_y = 5'd31;
        press(0, 1, 1, 0);
        pulse_ce();
        step(1);
        chk("wrap_left_x", probe_x, 31);
        chk("wrap_left_y", probe_y, 31);
        step(2);
        chk("prio_direction", direction, 1);
        press(0, 0, 1, 0);
        pulse_ce();
        step(1);
        chk("wrap_down_x", probe_x, 0);
        chk("wrap_down_y", probe_y, 0);
        step(2);
        chk("wrap_direction", direction, 2);

        // Overlapping tick is dropped
        press(0, 0, 0, 1);
        pulse_ce();
        step(1);
        ce = 1'b1;
        step(1);
        ce = 1'b0;
        step(1);
        chk("overlap_direction", direction, 3);
        chk("overlap_busy_n4", busy, 0);
        step(1);
        chk("overlap_busy_after", busy, 0);

        // Reset mid-evaluation
        press(1, 0, 0, 0);
        pulse_ce();
        step(1);
        reset = 1'b1;
        step(1);
        chk("midreset_busy", busy, 0);
        chk("midreset_direction", direction, RESET_DIR);
        reset = 1'b0;
        step(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
